cali_fmp_seq_ctrl: RTL and testbench

Sequencer for the auxpll multi-phase offset calibration engine.
- Resets and enables the engine and counts its 1024-cycle measurement windows.
- Samples the engine's DPHASE segment array at every window end and declares convergence once all segments are stable within a threshold for a set number of consecutive windows.
- Freezes the result for the phase-interpolation datapath; reports timeout if convergence is not reached.

---
 rtl/cali_fmp_pkg.sv | 23 ++
 rtl/cali_fmp_delta_cmp.sv | 32 +++
 rtl/cali_fmp_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cali_fmp_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cali_fmp_pkg.sv
// Shared constants and types for the auxpll multi-phase offset calibration sequencer.
package cali_fmp_pkg;

   localparam int unsigned MP_SEG_BIN  = 1;
   localparam int unsigned MP_SEG      = 2**MP_SEG_BIN;
   localparam int unsigned WF_PHASE    = 24;
   localparam int unsigned WIN_LEN_BIN = 10;
   localparam int unsigned SETTLE_WIN  = 2;
   localparam int unsigned CONV_NUM    = 4;
   localparam int unsigned MAX_WIN     = 255;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_SETTLE,
      ST_MEASURE,
      ST_DONE,
      ST_FAIL
   } state_t;

   typedef logic [WF_PHASE-1:0] phase_seg_t;

endpackage

// File: rtl/cali_fmp_delta_cmp.sv
// Per-segment |new - prev| <= thresh check; flags whether every segment is within threshold.
module cali_fmp_delta_cmp #(
   parameter int unsigned MP_SEG   = 2,
   parameter int unsigned WF_PHASE = 24
)(
   input  logic [MP_SEG*WF_PHASE-1:0] i_new_arr,
   input  logic [MP_SEG*WF_PHASE-1:0] i_prev_arr,
   input  logic [WF_PHASE-1:0]        i_thresh,
   output logic                       o_all_within
);

   logic [WF_PHASE:0] w_a;
   logic [WF_PHASE:0] w_b;
   logic [WF_PHASE:0] w_diff;

   // One extra bit keeps the magnitude exact: no modulo wrap across full scale.
   always_comb begin
      o_all_within = 1'b1;
      w_a          = '0;
      w_b          = '0;
      w_diff       = '0;
      for (int unsigned i = 0; i < MP_SEG; i++) begin
         w_a    = {1'b0, i_new_arr[i*WF_PHASE +: WF_PHASE]};
         w_b    = {1'b0, i_prev_arr[i*WF_PHASE +: WF_PHASE]};
         w_diff = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
         if (w_diff > {1'b0, i_thresh}) begin
            o_all_within = 1'b0;
         end
      end
   end

endmodule

// File: rtl/cali_fmp_seq_ctrl.sv
// Sequencer for the auxpll multi-phase offset calibration engine.
// Define CALI_FMP_TRACK_EN to keep the engine running in DONE and track slow drift.
module cali_fmp_seq_ctrl
   import cali_fmp_pkg::*;
#(
   parameter int unsigned MP_SEG_BIN  = cali_fmp_pkg::MP_SEG_BIN,
   parameter int unsigned WF_PHASE    = cali_fmp_pkg::WF_PHASE,
   parameter int unsigned WIN_LEN_BIN = cali_fmp_pkg::WIN_LEN_BIN,
   parameter int unsigned SETTLE_WIN  = cali_fmp_pkg::SETTLE_WIN,
   parameter int unsigned CONV_NUM    = cali_fmp_pkg::CONV_NUM,
   parameter int unsigned MAX_WIN     = cali_fmp_pkg::MAX_WIN
)(
   input  logic                                    CLK,
   input  logic                                    NRST,
   input  logic                                    START,
   input  logic                                    ABORT,
   input  logic [WF_PHASE-1:0]                     THRESH,
   input  logic [(2**MP_SEG_BIN)*WF_PHASE-1:0]     DPHASE_SEG_ARR,
   output logic                                    CALI_NRST,
   output logic                                    CALI_EN,
   output logic                                    BUSY,
   output logic                                    DONE,
   output logic                                    FAIL,
   output logic [7:0]                              WIN_CNT,
   output logic [(2**MP_SEG_BIN)*WF_PHASE-1:0]     DPHASE_OUT,
   output logic                                    DPHASE_VLD
);

   localparam int unsigned NSEG = 2**MP_SEG_BIN;
   localparam int unsigned AW   = NSEG*WF_PHASE;
   localparam int unsigned CW   = $clog2(CONV_NUM+1);

   state_t                 r_state;
   logic                   r_cali_nrst;
   logic                   r_cali_en;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_fail;
   logic                   r_vld;
   logic [WIN_LEN_BIN-1:0] r_wcnt;
   logic [7:0]             r_win_cnt;
   logic [CW-1:0]          r_conv_cnt;
   logic [AW-1:0]          r_prev;
   logic [AW-1:0]          r_dout;
`ifdef CALI_FMP_TRACK_EN
   logic                   r_drift;
`endif

   logic                   w_win_end;
   logic                   w_within;
   logic                   w_idle_like;
   logic [7:0]             w_win_cnt_nxt;
   logic [CW-1:0]          w_conv_nxt;

   cali_fmp_delta_cmp #(
      .MP_SEG   (NSEG),
      .WF_PHASE (WF_PHASE)
   ) u_delta_cmp (
      .i_new_arr    (DPHASE_SEG_ARR),
      .i_prev_arr   (r_prev),
      .i_thresh     (THRESH),
      .o_all_within (w_within)
   );

   assign w_win_end     = &r_wcnt;
   assign w_idle_like   = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_FAIL);
   assign w_win_cnt_nxt = (&r_win_cnt) ? r_win_cnt : r_win_cnt + 8'd1;
   assign w_conv_nxt    = w_within ? r_conv_cnt + CW'(1) : '0;

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         r_state     <= ST_IDLE;
         r_cali_nrst <= 1'b1;
         r_cali_en   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_fail      <= 1'b0;
         r_vld       <= 1'b0;
         r_wcnt      <= '0;
         r_win_cnt   <= '0;
         r_conv_cnt  <= '0;
         r_prev      <= '0;
         r_dout      <= '0;
`ifdef CALI_FMP_TRACK_EN
         r_drift     <= 1'b0;
`endif
      end else begin
`ifdef CALI_FMP_TRACK_EN
         r_drift <= 1'b0;
`endif
         if (ABORT) begin
            r_state     <= ST_IDLE;
            r_cali_nrst <= 1'b1;
            r_cali_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_vld       <= 1'b0;
         end else if (START && w_idle_like) begin
            // DPHASE_OUT is deliberately kept across a restart.
            r_state     <= ST_CLR;
            r_cali_nrst <= 1'b0;
            r_cali_en   <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_vld       <= 1'b0;
            r_wcnt      <= '0;
            r_win_cnt   <= '0;
            r_conv_cnt  <= '0;
            r_prev      <= '0;
         end else begin
            case (r_state)
               ST_CLR: begin
                  r_state     <= ST_SETTLE;
                  r_cali_nrst <= 1'b1;
                  r_cali_en   <= 1'b1;
               end
               ST_SETTLE, ST_MEASURE: begin
                  r_wcnt <= r_wcnt + WIN_LEN_BIN'(1);
                  if (w_win_end) begin
                     r_win_cnt <= w_win_cnt_nxt;
                     r_prev    <= DPHASE_SEG_ARR;
                     if (r_state == ST_SETTLE) begin
                        if (w_win_cnt_nxt == 8'(SETTLE_WIN)) begin
                           r_state <= ST_MEASURE;
                        end
                     end else begin
                        r_conv_cnt <= w_conv_nxt;
                        // Convergence is tested first so it wins over budget expiry.
                        if (w_conv_nxt == CW'(CONV_NUM)) begin
                           r_state <= ST_DONE;
                           r_busy  <= 1'b0;
                           r_done  <= 1'b1;
                           r_vld   <= 1'b1;
                           r_dout  <= DPHASE_SEG_ARR;
`ifdef CALI_FMP_TRACK_EN
                           r_cali_en <= 1'b1;
`else
                           r_cali_en <= 1'b0;
`endif
                        end else if (w_win_cnt_nxt == 8'(MAX_WIN)) begin
                           r_state   <= ST_FAIL;
                           r_busy    <= 1'b0;
                           r_fail    <= 1'b1;
                           r_cali_en <= 1'b0;
                        end
                     end
                  end
               end
`ifdef CALI_FMP_TRACK_EN
               ST_DONE: begin
                  r_wcnt <= r_wcnt + WIN_LEN_BIN'(1);
                  if (w_win_end) begin
                     r_win_cnt <= w_win_cnt_nxt;
                     r_prev    <= DPHASE_SEG_ARR;
                     if (w_within) begin
                        r_dout <= DPHASE_SEG_ARR;
                     end else begin
                        r_drift <= 1'b1;
                     end
                  end
               end
`endif
               default: begin
               end
            endcase
         end
      end
   end

   assign CALI_NRST  = r_cali_nrst;
   assign CALI_EN    = r_cali_en;
   assign BUSY       = r_busy;
   assign DONE       = r_done;
   assign FAIL       = r_fail;
   assign WIN_CNT    = r_win_cnt;
   assign DPHASE_OUT = r_dout;
   assign DPHASE_VLD = r_vld;

endmodule

// File: tb/tb_cali_fmp_seq_ctrl.sv
// Directed bench for cali_fmp_seq_ctrl; DONE/FAIL events are checked against a scoreboard queue.
module tb_cali_fmp_seq_ctrl;
   import cali_fmp_pkg::*;

   localparam int unsigned TB_WIN_BIN = 6;
   localparam int          L          = 2**TB_WIN_BIN;
   localparam int          AW         = MP_SEG*WF_PHASE;
`ifdef CALI_FMP_TRACK_EN
   localparam logic        TRK        = 1'b1;
`else
   localparam logic        TRK        = 1'b0;
`endif

   localparam logic [AW-1:0] ARR_A = {phase_seg_t'(24'h400000), phase_seg_t'(24'h800000)};
   localparam logic [AW-1:0] V1    = {phase_seg_t'(24'h123456), phase_seg_t'(24'h000100)};
   localparam logic [AW-1:0] V2    = {phase_seg_t'(24'h123466), phase_seg_t'(24'h0000F0)};
   localparam logic [AW-1:0] V3    = {phase_seg_t'(24'h123477), phase_seg_t'(24'h0000F0)};

   typedef struct {
      logic [1:0]    kind;
      int            at;
      logic [7:0]    win;
      logic [AW-1:0] dout;
      logic          en;
   } exp_t;

   logic                CLK            = 1'b0;
   logic                NRST           = 1'b1;
   logic                START          = 1'b0;
   logic                ABORT          = 1'b0;
   logic [WF_PHASE-1:0] THRESH         = 24'd16;
   logic [AW-1:0]       DPHASE_SEG_ARR = '0;
   logic                CALI_NRST;
   logic                CALI_EN;
   logic                BUSY;
   logic                DONE;
   logic                FAIL;
   logic [7:0]          WIN_CNT;
   logic [AW-1:0]       DPHASE_OUT;
   logic                DPHASE_VLD;

   int            cyc     = 0;
   int            n_tests = 0;
   int            n_fail  = 0;
   exp_t          sb[$];
   exp_t          m_e;
   logic          m_prev_ev = 1'b0;
   logic [AW-1:0] last_out;

   cali_fmp_seq_ctrl #(
      .WIN_LEN_BIN (TB_WIN_BIN)
   ) dut (
      .CLK            (CLK),
      .NRST           (NRST),
      .START          (START),
      .ABORT          (ABORT),
      .THRESH         (THRESH),
      .DPHASE_SEG_ARR (DPHASE_SEG_ARR),
      .CALI_NRST      (CALI_NRST),
      .CALI_EN        (CALI_EN),
      .BUSY           (BUSY),
      .DONE           (DONE),
      .FAIL           (FAIL),
      .WIN_CNT        (WIN_CNT),
      .DPHASE_OUT     (DPHASE_OUT),
      .DPHASE_VLD     (DPHASE_VLD)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) tick(1);
   endtask

   task automatic do_start(output int t);
      START = 1'b1;
      t     = cyc;
      tick(1);
      START = 1'b0;
   endtask

   function automatic logic [AW-1:0] add_seg(input logic [AW-1:0] a, input int d);
      logic [AW-1:0] r;
      r = a;
      for (int i = 0; i < int'(MP_SEG); i++)
         r[i*WF_PHASE +: WF_PHASE] = a[i*WF_PHASE +: WF_PHASE] + WF_PHASE'(d);
      return r;
   endfunction

   // Monitor: every rising DONE/FAIL must match the oldest queued expectation.
   always @(negedge CLK) begin
      if (NRST && (DONE || FAIL) && !m_prev_ev) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got DONE=%0b FAIL=%0b at cycle %0d, required none", DONE, FAIL, cyc);
         end else begin
            m_e = sb.pop_front();
            chk("ev_kind", {62'd0, FAIL, DONE}, {62'd0, m_e.kind});
            chk("ev_cycle", cyc, m_e.at);
            chk("ev_win_cnt", WIN_CNT, m_e.win);
            chk("ev_dphase_out", DPHASE_OUT, m_e.dout);
            chk("ev_vld", DPHASE_VLD, m_e.kind == 2'b01);
            chk("ev_cali_en", CALI_EN, m_e.en);
            chk("ev_busy", BUSY, 0);
         end
      end
      m_prev_ev = NRST && (DONE || FAIL);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d, required earlier end", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         t;
      int         d;
      phase_seg_t s0;
      phase_seg_t s1;

      // Reset values
      #1 NRST = 1'b0;
      #2;
      chk("rst_cali_nrst", CALI_NRST, 1);
      chk("rst_cali_en", CALI_EN, 0);
      chk("rst_status", {BUSY, DONE, FAIL, DPHASE_VLD}, 0);
      chk("rst_win_cnt", WIN_CNT, 0);
      chk("rst_dphase_out", DPHASE_OUT, 0);
      @(posedge CLK);
      #1 NRST = 1'b1;
      tick(2);

      // Constant array converges after 2 settle + 4 measure windows
      DPHASE_SEG_ARR = ARR_A;
      do_start(t);
      sb.push_back('{2'b01, t + 2 + 6*L, 8'd6, ARR_A, TRK});
      chk("clr_cali_nrst", CALI_NRST, 0);
      chk("clr_cali_en", CALI_EN, 0);
      chk("clr_busy", BUSY, 1);
      tick(1);
      chk("settle_cali_nrst", CALI_NRST, 1);
      chk("settle_cali_en", CALI_EN, 1);
      d = t + 2 + 6*L;
      wait_cyc(d + 2*L);
      chk("done_level", {DONE, DPHASE_VLD}, 2'b11);
      chk("done_out_hold", DPHASE_OUT, ARR_A);
      chk("done_cali_en", CALI_EN, TRK);
`ifdef CALI_FMP_TRACK_EN
      DPHASE_SEG_ARR = add_seg(ARR_A, 8);
      wait_cyc(d + 3*L);
      chk("track_follow1", DPHASE_OUT, add_seg(ARR_A, 8));
      DPHASE_SEG_ARR = add_seg(ARR_A, 16);
      wait_cyc(d + 4*L);
      chk("track_follow2", DPHASE_OUT, add_seg(ARR_A, 16));
      DPHASE_SEG_ARR = add_seg(ARR_A, 116);
      wait_cyc(d + 5*L);
      chk("track_hold", DPHASE_OUT, add_seg(ARR_A, 16));
      chk("track_vld", DPHASE_VLD, 1);
      last_out = add_seg(ARR_A, 16);
`else
      last_out = ARR_A;
`endif

      // Count reset: +-16 accepted, +17 restarts the stable count; START while busy ignored
      DPHASE_SEG_ARR = V1;
      do_start(t);
      chk("restart_clears", {DONE, FAIL, DPHASE_VLD}, 0);
      chk("restart_out_held", DPHASE_OUT, last_out);
      sb.push_back('{2'b01, t + 2 + 10*L, 8'd10, V3, TRK});
      for (int k = 1; k <= 10; k++) begin
         wait_cyc(t + 2 + (k-1)*L);
         DPHASE_SEG_ARR = (k <= 2) ? V1 : (k <= 5) ? V2 : V3;
         if (k == 5) begin
            tick(5);
            START = 1'b1;
            tick(1);
            START = 1'b0;
         end
      end
      wait_cyc(t + 3 + 10*L);
      last_out = V3;

      // Instability: never within THRESH, runs out the 255-window budget
      do_start(t);
      sb.push_back('{2'b10, t + 2 + 255*L, 8'd255, last_out, 1'b0});
      for (int k = 1; k <= 255; k++) begin
         wait_cyc(t + 2 + (k-1)*L);
         if (k <= 130) begin
            s1 = (k % 2 == 0) ? 24'h555014 : 24'h555000;
            s0 = 24'h000000;
         end else begin
            s1 = 24'h555014;
            s0 = (k % 2 == 1) ? 24'hFFFFF0 : 24'h000000;
         end
         DPHASE_SEG_ARR = {s1, s0};
      end
      wait_cyc(t + 3 + 255*L);
      chk("fail_level", {FAIL, DONE, DPHASE_VLD, BUSY}, 4'b1000);

      // START while busy, then ABORT together with START
      DPHASE_SEG_ARR = V1;
      do_start(t);
      wait_cyc(t + 2 + 2*L + 5);
      START = 1'b1;
      tick(1);
      START = 1'b0;
      chk("busy_start_ignored", WIN_CNT, 2);
      wait_cyc(t + 2 + 3*L + 5);
      chk("win_cnt_continues", WIN_CNT, 3);
      START = 1'b1;
      ABORT = 1'b1;
      tick(1);
      START = 1'b0;
      ABORT = 1'b0;
      chk("abort_busy", BUSY, 0);
      chk("abort_cali", {CALI_NRST, CALI_EN}, 2'b10);
      chk("abort_status", {DONE, FAIL, DPHASE_VLD}, 0);
      chk("abort_out_held", DPHASE_OUT, last_out);
      tick(3);
      chk("abort_stays_idle", {BUSY, CALI_NRST}, 2'b01);

      // Asynchronous reset mid-MEASURE
      do_start(t);
      wait_cyc(t + 2 + 3*L + 7);
      NRST = 1'b0;
      #1;
      chk("nrst_cali", {CALI_NRST, CALI_EN}, 2'b10);
      chk("nrst_status", {BUSY, DONE, FAIL, DPHASE_VLD}, 0);
      chk("nrst_win_cnt", WIN_CNT, 0);
      chk("nrst_dphase_out", DPHASE_OUT, 0);
      @(posedge CLK);
      #1 NRST = 1'b1;
      tick(2);

      chk("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
